// File: rtl/otter_fetch_queue.sv
// otter_fetch_queue
// -----------------
// Instruction-fetch front end for the pipelined OTTER. It owns the fetch PC,
// issues word-aligned requests on the instruction port of memory, and holds
// the returned instructions in a small in-order queue that feeds the IF/DE
// boundary. Memory latency, decode stalls and execute-stage redirects are
// absorbed here without losing or duplicating instructions.
//
// Parameters
//   DEPTH      queue entries, also the maximum number of outstanding requests
//              (power of two, at least 2)
//   RESET_VEC  first fetch address after reset
//
// Ports
//   CLK            clock, all state on the rising edge
//   RESET          asynchronous active-low reset
//   IMEM_REQ       fetch request valid
//   IMEM_ADDR      fetch address (word aligned)
//   IMEM_GNT       request accepted this cycle
//   IMEM_RVALID    response valid, responses return in request order
//   IMEM_RDATA     returned instruction word
//   REDIRECT       execute-stage taken branch/jump, flushes the front end
//   REDIRECT_PC    new fetch target
//   DE_STALL       decode cannot accept the head instruction
//   IF_DE_VALID    head entry valid
//   IF_DE_IR       head instruction
//   IF_DE_PC       head instruction address
//   IF_DE_NEXT_PC  head instruction address + 4
//   FETCH_ERR      sticky protocol/alignment error, cleared only by reset

module otter_fetch_queue #(
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RESET,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_GNT,
   input  logic        IMEM_RVALID,
   input  logic [31:0] IMEM_RDATA,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC,
   input  logic        DE_STALL,
   output logic        IF_DE_VALID,
   output logic [31:0] IF_DE_IR,
   output logic [31:0] IF_DE_PC,
   output logic [31:0] IF_DE_NEXT_PC,
   output logic        FETCH_ERR
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = CW + 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [31:0]   pc_q  [DEPTH];
   logic [31:0]   npc_q [DEPTH];
   logic [31:0]   ir_q  [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] out_cnt;
   logic [CW-1:0] drop_cnt;
   logic          fetch_err;

   logic          pop;
   logic          grant;
   logic          rsp_live;
   logic          push;
   logic [SW-1:0] credits_used;
   logic [31:0]   redirect_target;

   // A queue slot is reserved for every request in flight, so a new request
   // is only allowed while occupied plus outstanding entries (less the one
   // leaving this cycle) stay below DEPTH. This is what makes a push into a
   // full queue impossible.
   assign pop          = IF_DE_VALID & ~DE_STALL & ~REDIRECT;
   assign credits_used = SW'(count) + SW'(out_cnt) - SW'(pop);
   assign IMEM_REQ     = RESET & ~REDIRECT & (credits_used < SW'(DEPTH));
   assign IMEM_ADDR    = fetch_pc;

   assign grant           = IMEM_REQ & IMEM_GNT;
   assign rsp_live        = IMEM_RVALID & (out_cnt != '0);
   assign push            = rsp_live & (drop_cnt == '0) & ~REDIRECT;
   assign redirect_target = {REDIRECT_PC[31:2], 2'b00};

   // Entries store PC+4 alongside the PC so every IF/DE output comes straight
   // out of queue storage selected by the head pointer.
   assign IF_DE_VALID   = (count != '0);
   assign IF_DE_IR      = ir_q[head];
   assign IF_DE_PC      = pc_q[head];
   assign IF_DE_NEXT_PC = npc_q[head];
   assign FETCH_ERR     = fetch_err;

   // Fetch PC, credit counters, queue storage and the sticky error flag.
   // A redirect wins over everything: the queue is emptied, both PCs jump to
   // the target, and every response still in flight belongs to the abandoned
   // path and is marked for discard (minus the one arriving right now, which
   // is itself thrown away).
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         fetch_pc  <= RESET_VEC;
         rsp_pc    <= RESET_VEC;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         out_cnt   <= '0;
         drop_cnt  <= '0;
         fetch_err <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_q[i]  <= '0;
            npc_q[i] <= '0;
            ir_q[i]  <= '0;
         end
      end else begin
         if (grant) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         out_cnt <= out_cnt + CW'(grant) - CW'(rsp_live);

         if (IMEM_RVALID && (out_cnt == '0)) begin
            fetch_err <= 1'b1;
         end

         if (REDIRECT) begin
            fetch_pc <= redirect_target;
            rsp_pc   <= redirect_target;
            head     <= tail;
            count    <= '0;
            drop_cnt <= out_cnt - CW'(rsp_live);
            if (REDIRECT_PC[1:0] != 2'b00) begin
               fetch_err <= 1'b1;
            end
         end else begin
            if (rsp_live && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
               pc_q[tail]  <= rsp_pc;
               npc_q[tail] <= rsp_pc + 32'd4;
               ir_q[tail]  <= IMEM_RDATA;
               tail        <= tail + PW'(1);
               rsp_pc      <= rsp_pc + 32'd4;
            end
            if (pop) begin
               head <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

endmodule

// File: tb/tb_otter_fetch_queue.sv
// tb_otter_fetch_queue
// --------------------
// Bench for otter_fetch_queue. An in-order memory model with adjustable
// latency answers every granted request with (address ^ KEY). Expected
// instructions are queued by the stimulus; a monitor pops one entry each
// time decode accepts the head and compares PC, IR and next PC. Directed
// checks cover reset, request timing, stalls, redirects and error flagging.

module tb_otter_fetch_queue;

   localparam logic [31:0] KEY = 32'hABCD_0000;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_GNT = 1'b1;
   logic        IMEM_RVALID = 1'b0;
   logic [31:0] IMEM_RDATA = 32'h0;
   logic        REDIRECT = 1'b0;
   logic [31:0] REDIRECT_PC = 32'h0;
   logic        DE_STALL = 1'b0;
   logic        IF_DE_VALID;
   logic [31:0] IF_DE_IR;
   logic [31:0] IF_DE_PC;
   logic [31:0] IF_DE_NEXT_PC;
   logic        FETCH_ERR;

   int          checks = 0;
   int          errors = 0;
   int          pops = 0;
   int          cyc = 0;
   int          lat = 1;
   logic        inject = 1'b0;

   logic [31:0] exp_pc[$];
   logic [31:0] exp_ir[$];
   logic [31:0] pend_addr[$];
   int          pend_due[$];

   always #5 CLK = ~CLK;

   otter_fetch_queue #(
      .DEPTH(2),
      .RESET_VEC(32'h0000_0000)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .IMEM_REQ(IMEM_REQ),
      .IMEM_ADDR(IMEM_ADDR),
      .IMEM_GNT(IMEM_GNT),
      .IMEM_RVALID(IMEM_RVALID),
      .IMEM_RDATA(IMEM_RDATA),
      .REDIRECT(REDIRECT),
      .REDIRECT_PC(REDIRECT_PC),
      .DE_STALL(DE_STALL),
      .IF_DE_VALID(IF_DE_VALID),
      .IF_DE_IR(IF_DE_IR),
      .IF_DE_PC(IF_DE_PC),
      .IF_DE_NEXT_PC(IF_DE_NEXT_PC),
      .FETCH_ERR(FETCH_ERR)
   );

   // Memory response side: one in-order response per cycle once its due
   // cycle arrives, or a single spurious response when requested.
   initial begin
      forever begin
         @(posedge CLK);
         cyc++;
         #1;
         IMEM_RVALID = 1'b0;
         if (!RESET) begin
            pend_addr.delete();
            pend_due.delete();
            inject = 1'b0;
         end else if (inject) begin
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = 32'hDEAD_BEEF;
            inject      = 1'b0;
         end else if ((pend_due.size() > 0) && (pend_due[0] <= cyc + 1)) begin
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = pend_addr[0] ^ KEY;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
         end
      end
   end

   // Memory request side: a request seen here is granted at the next edge.
   initial begin
      forever begin
         @(negedge CLK);
         if (RESET && IMEM_REQ && IMEM_GNT) begin
            pend_addr.push_back(IMEM_ADDR);
            pend_due.push_back(cyc + 1 + lat);
         end
      end
   end

   // Scoreboard monitor: every accepted head must match the oldest expectation.
   initial begin
      logic [31:0] epc;
      logic [31:0] eir;
      forever begin
         @(negedge CLK);
         if (RESET && IF_DE_VALID && !DE_STALL && !REDIRECT) begin
            pops++;
            checks++;
            if (exp_pc.size() == 0) begin
               errors++;
               $display("[TB] FAIL sb_unexpected pc=%h ir=%h required no entry", IF_DE_PC, IF_DE_IR);
            end else begin
               epc = exp_pc.pop_front();
               eir = exp_ir.pop_front();
               if ((IF_DE_PC !== epc) || (IF_DE_IR !== eir) || (IF_DE_NEXT_PC !== epc + 32'd4)) begin
                  errors++;
                  $display("[TB] FAIL sb_entry pc=%h ir=%h npc=%h required pc=%h ir=%h npc=%h",
                           IF_DE_PC, IF_DE_IR, IF_DE_NEXT_PC, epc, eir, epc + 32'd4);
               end
            end
         end
      end
   end

   initial begin
      #20000;
      errors++;
      $display("[TB] FAIL watchdog time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic at_neg();
      @(negedge CLK);
   endtask

   task automatic push_stream(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         exp_pc.push_back(base + 32'(4 * i));
         exp_ir.push_back((base + 32'(4 * i)) ^ KEY);
      end
   endtask

   task automatic start_reset();
      RESET = 1'b0;
      exp_pc.delete();
      exp_ir.delete();
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      at_neg();
      check_output("rst_valid", 32'(IF_DE_VALID), 32'h0);
      check_output("rst_ir", IF_DE_IR, 32'h0);
      check_output("rst_pc", IF_DE_PC, 32'h0);
      check_output("rst_npc", IF_DE_NEXT_PC, 32'h0);
      check_output("rst_err", 32'(FETCH_ERR), 32'h0);
      check_output("rst_req", 32'(IMEM_REQ), 32'h0);

      // Streaming from RESET_VEC at latency 1
      step();
      pops = 0;
      push_stream(32'h0, 20);
      RESET = 1'b1;
      at_neg();
      check_output("c0_req", 32'(IMEM_REQ), 32'h1);
      check_output("c0_addr", IMEM_ADDR, 32'h0);
      check_output("c0_valid", 32'(IF_DE_VALID), 32'h0);
      step();
      at_neg();
      check_output("c1_addr", IMEM_ADDR, 32'h4);
      check_output("c1_valid", 32'(IF_DE_VALID), 32'h0);
      step();
      at_neg();
      check_output("c2_valid", 32'(IF_DE_VALID), 32'h1);
      check_output("c2_pc", IF_DE_PC, 32'h0);
      check_output("c2_addr", IMEM_ADDR, 32'h8);

      // Decode stall for five cycles
      repeat (8) step();
      DE_STALL = 1'b1;
      for (int i = 0; i < 5; i++) begin
         at_neg();
         check_output("stall_pc", IF_DE_PC, 32'h20);
         check_output("stall_req", 32'(IMEM_REQ), 32'h0);
         if (i < 4) step();
      end
      step();
      DE_STALL = 1'b0;
      at_neg();
      check_output("unstall_req", 32'(IMEM_REQ), 32'h1);
      check_output("unstall_addr", IMEM_ADDR, 32'h28);
      repeat (6) step();
      check_output("stream_pops", 32'(pops), 32'd14);

      // Mid-run reset, then latency 3 with a redirect over two stale requests
      start_reset();
      #1;
      check_output("async_rst_valid", 32'(IF_DE_VALID), 32'h0);
      check_output("async_rst_req", 32'(IMEM_REQ), 32'h0);
      lat = 3;
      step();
      step();
      pops = 0;
      push_stream(32'h100, 12);
      RESET = 1'b1;
      step();
      step();
      REDIRECT    = 1'b1;
      REDIRECT_PC = 32'h100;
      at_neg();
      check_output("redir_req", 32'(IMEM_REQ), 32'h0);
      step();
      REDIRECT = 1'b0;
      at_neg();
      check_output("stale_credit_req", 32'(IMEM_REQ), 32'h0);
      step();
      at_neg();
      check_output("redir_addr", IMEM_ADDR, 32'h100);
      check_output("redir_req_resume", 32'(IMEM_REQ), 32'h1);
      check_output("stale_valid_c4", 32'(IF_DE_VALID), 32'h0);
      step();
      at_neg();
      check_output("stale_valid_c5", 32'(IF_DE_VALID), 32'h0);
      repeat (3) step();
      at_neg();
      check_output("redir_first_valid", 32'(IF_DE_VALID), 32'h1);
      check_output("redir_first_pc", IF_DE_PC, 32'h100);
      repeat (9) step();
      check_output("lat3_pops", 32'(pops), 32'd5);

      // Redirect coinciding with a response and a consumable head
      start_reset();
      lat = 1;
      step();
      step();
      pops = 0;
      push_stream(32'h40, 16);
      RESET = 1'b1;
      step();
      step();
      REDIRECT    = 1'b1;
      REDIRECT_PC = 32'h40;
      at_neg();
      check_output("pre_flush_valid", 32'(IF_DE_VALID), 32'h1);
      check_output("pre_flush_pc", IF_DE_PC, 32'h0);
      step();
      REDIRECT = 1'b0;
      at_neg();
      check_output("post_flush_valid", 32'(IF_DE_VALID), 32'h0);
      check_output("post_flush_req", 32'(IMEM_REQ), 32'h1);
      check_output("post_flush_addr", IMEM_ADDR, 32'h40);
      step();
      step();
      at_neg();
      check_output("flush_first_pc", IF_DE_PC, 32'h40);

      // Grant withheld for four cycles
      repeat (3) step();
      IMEM_GNT = 1'b0;
      for (int i = 0; i < 4; i++) begin
         at_neg();
         check_output("nogrant_req", 32'(IMEM_REQ), 32'h1);
         check_output("nogrant_addr", IMEM_ADDR, 32'h54);
         if (i < 3) step();
      end
      step();
      IMEM_GNT = 1'b1;
      repeat (5) step();
      check_output("gnt_pops", 32'(pops), 32'd8);

      // Spurious response while idle, then a misaligned redirect
      start_reset();
      IMEM_GNT = 1'b0;
      step();
      step();
      pops = 0;
      push_stream(32'h100, 16);
      RESET  = 1'b1;
      inject = 1'b1;
      at_neg();
      check_output("err_c0", 32'(FETCH_ERR), 32'h0);
      step();
      at_neg();
      check_output("err_c1", 32'(FETCH_ERR), 32'h0);
      step();
      at_neg();
      check_output("err_spurious", 32'(FETCH_ERR), 32'h1);
      check_output("spurious_valid", 32'(IF_DE_VALID), 32'h0);
      step();
      REDIRECT    = 1'b1;
      REDIRECT_PC = 32'h102;
      step();
      REDIRECT = 1'b0;
      IMEM_GNT = 1'b1;
      at_neg();
      check_output("misalign_addr", IMEM_ADDR, 32'h100);
      check_output("misalign_err", 32'(FETCH_ERR), 32'h1);
      repeat (7) step();
      check_output("misalign_pops", 32'(pops), 32'd5);
      check_output("err_sticky", 32'(FETCH_ERR), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
